vga_sync_gen: RTL and testbench

- Generates VGA raster timing from the pixel clock: horizontal/vertical counters, `hsync`, `vsync`, `active`, pixel coordinates and line/frame strobes.
- Sits upstream of the per-pixel colour logic and drives the `active` input of the RGB output-blanking stage; `hpos`/`vpos` feed the pixel generators.
- Default timing is 640x480 @ 60 Hz, 800x525 total, for a 25.175 MHz pixel rate.

---
 rtl/vga_sync_gen_pkg.sv | 33 +++
 rtl/vga_sync_gen_if.sv | 25 ++
 rtl/vga_sync_gen_axis_counter.sv | 73 +++++++
 rtl/vga_sync_gen.sv | 85 ++++++++
 tb/tb_vga_sync_gen.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared types and constants for the VGA raster generator: phase enum,
// 640x480@60 default timing, and the axis-total helpers used for elaboration checks.
package vga_pkg;

    localparam int CW        = 10;
    localparam int MAX_TOTAL = 1 << CW;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    function automatic int axis_total(input int a, input int f, input int s, input int b);
        return a + f + s + b;
    endfunction

    // An axis fits only if its whole period is countable in CW bits.
    function automatic bit timing_ok(input int a, input int f, input int s, input int b);
        return axis_total(a, f, s, b) <= MAX_TOTAL;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster bundle between the sync generator (master) and the pixel/blanking logic (slave).
interface vga_sync_gen_if;
    import vga_pkg::*;

    logic          pix_en;
    logic [CW-1:0] hpos;
    logic [CW-1:0] vpos;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic          line_start;
    logic          frame_start;
    logic [7:0]    frame_cnt;

    modport master (
        input  pix_en,
        output hpos, vpos, hsync, vsync, active, line_start, frame_start, frame_cnt
    );

    modport slave (
        output pix_en,
        input  hpos, vpos, hsync, vsync, active, line_start, frame_start, frame_cnt
    );

endinterface

// File: rtl/vga_sync_gen_axis_counter.sv
// One raster axis: a wrapping counter plus an ACTIVE/FRONT/SYNC/BACK phase FSM,
// both advancing only on step. Used once for horizontal, once for vertical.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACT   = DEF_H_ACTIVE,
    parameter int FRONT = DEF_H_FRONT,
    parameter int SYNC  = DEF_H_SYNC,
    parameter int BACK  = DEF_H_BACK
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] count_o,
    output phase_e        phase_o,
    output logic          wrap_o,
    output logic          in_sync_o
);

    localparam int TOTAL = axis_total(ACT, FRONT, SYNC, BACK);
    localparam logic [CW-1:0] END_ACT   = CW'(ACT - 1);
    localparam logic [CW-1:0] END_FRONT = CW'(ACT + FRONT - 1);
    localparam logic [CW-1:0] END_SYNC  = CW'(ACT + FRONT + SYNC - 1);
    localparam logic [CW-1:0] END_BACK  = CW'(TOTAL - 1);

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] phase_end;
    logic          at_end;
    phase_e        phase_q, phase_d;

    assign at_end  = (count_q == END_BACK);
    assign count_d = at_end ? '0 : count_q + CW'(1);
    assign wrap_o  = step & at_end;
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst)       count_q <= '0;
        else if (step) count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (rst)       phase_q <= PH_ACTIVE;
        else if (step) phase_q <= phase_d;
    end

    always_comb begin
        phase_end = END_BACK;
        unique case (phase_q)
            PH_ACTIVE: phase_end = END_ACT;
            PH_FRONT:  phase_end = END_FRONT;
            PH_SYNC:   phase_end = END_SYNC;
            PH_BACK:   phase_end = END_BACK;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        if (count_q == phase_end) begin
            unique case (phase_q)
                PH_ACTIVE: phase_d = PH_FRONT;
                PH_FRONT:  phase_d = PH_SYNC;
                PH_SYNC:   phase_d = PH_BACK;
                PH_BACK:   phase_d = PH_ACTIVE;
            endcase
        end
    end

    always_comb begin
        phase_o   = phase_q;
        in_sync_o = (phase_q == PH_SYNC);
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator; all outputs registered from the axis counters.
// Define VGA_SYNC_GEN_FRAME_CNT_EN to build the 8-bit frame counter (else frame_cnt = 0).
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);

    if (!timing_ok(H_ACTIVE, H_FRONT, H_SYNC, H_BACK) ||
        !timing_ok(V_ACTIVE, V_FRONT, V_SYNC, V_BACK)) begin : g_bad_timing
        $error("vga_sync_gen: axis total exceeds %0d", MAX_TOTAL);
    end

    logic [CW-1:0] h_cnt, v_cnt;
    phase_e        h_phase, v_phase;
    logic          h_wrap, v_wrap, h_in_sync, v_in_sync;

    vga_axis_counter #(.ACT(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)) u_h (
        .clk(clk), .rst(rst), .step(vga.pix_en),
        .count_o(h_cnt), .phase_o(h_phase), .wrap_o(h_wrap), .in_sync_o(h_in_sync)
    );

    // h_wrap already carries pix_en, so the vertical axis steps once per line.
    vga_axis_counter #(.ACT(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)) u_v (
        .clk(clk), .rst(rst), .step(h_wrap),
        .count_o(v_cnt), .phase_o(v_phase), .wrap_o(v_wrap), .in_sync_o(v_in_sync)
    );

    logic [CW-1:0] hpos_q, vpos_q;
    logic          hsync_q, vsync_q, active_q, line_start_q, frame_start_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hpos_q        <= '0;
            vpos_q        <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (vga.pix_en) begin
            hpos_q        <= h_cnt;
            vpos_q        <= v_cnt;
            hsync_q       <= h_in_sync ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= v_in_sync ? SYNC_POL : ~SYNC_POL;
            active_q      <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            line_start_q  <= (h_cnt == '0);
            frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign vga.hpos        = hpos_q;
    assign vga.vpos        = vpos_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.active      = active_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)         frame_cnt_q <= '0;
        else if (v_wrap) frame_cnt_q <= frame_cnt_q + 8'd1;
    end

    assign vga.frame_cnt = frame_cnt_q;
`else
    assign vga.frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a reduced-timing instance for raster/frame checks
// and a default 640x480 instance for one full line of real timing.
module tb_vga_sync_gen;
    import vga_pkg::*;

    localparam int HA = 10, HF = 2, HS = 3, HB = 1;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = 16, VT = 10, FT = 160;
`ifdef VGA_SYNC_GEN_FRAME_CNT_EN
    localparam bit FCE = 1'b1;
`else
    localparam bit FCE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_sync_gen_if vif ();
    vga_sync_gen_if dif ();
    assign dif.pix_en = 1'b1;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)
    ) dut (.clk(clk), .rst(rst), .vga(vif));

    vga_sync_gen dut_d (.clk(clk), .rst(rst), .vga(dif));

    int n_chk = 0, n_pass = 0;
    int eh, ev, errs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic adv;
        eh++;
        if (eh == HT) begin
            eh = 0;
            ev++;
            if (ev == VT) ev = 0;
        end
    endtask

    // Compare every decoded output against the expected pixel (eh, ev).
    task automatic model_cmp;
        logic a, hs, vs, ls, fs;
        a  = (eh < HA) && (ev < VA);
        hs = !((eh >= HA + HF) && (eh <= HA + HF + HS - 1));
        vs = !((ev >= VA + VF) && (ev <= VA + VF + VS - 1));
        ls = (eh == 0);
        fs = (eh == 0) && (ev == 0);
        if (vif.hpos !== CW'(eh) || vif.vpos !== CW'(ev) || vif.active !== a ||
            vif.hsync !== hs || vif.vsync !== vs || vif.line_start !== ls ||
            vif.frame_start !== fs)
            errs++;
    endtask

    initial begin
        int act, act_vb, hsl, vsl, lsn, fsn, gap_bad, last_ls, k, fc_err, fc_max;
        int d_act, d_hsl, d_hbad, d_ls, d_vsl;
        logic prev_ls, found;

        // reset
        rst = 1'b1;
        vif.pix_en = 1'b1;
        repeat (3) tick;
        chk("rst_hpos", vif.hpos, 0);
        chk("rst_vpos", vif.vpos, 0);
        chk("rst_active", vif.active, 0);
        chk("rst_hsync", vif.hsync, 1);
        chk("rst_vsync", vif.vsync, 1);
        chk("rst_line_start", vif.line_start, 0);
        chk("rst_frame_start", vif.frame_start, 0);
        chk("rst_frame_cnt", vif.frame_cnt, 0);

        rst = 1'b0;
        tick;
        chk("first_hpos", vif.hpos, 0);
        chk("first_vpos", vif.vpos, 0);
        chk("first_active", vif.active, 1);
        chk("first_line_start", vif.line_start, 1);
        chk("first_frame_start", vif.frame_start, 1);

        // one ungated frame
        eh = 0; ev = 0; errs = 0;
        act = 0; act_vb = 0; hsl = 0; vsl = 0; lsn = 0; fsn = 0; gap_bad = 0; last_ls = -1;
        for (int i = 0; i < FT; i++) begin
            model_cmp();
            if (vif.active) act++;
            if (vif.active && vif.vpos >= CW'(VA)) act_vb++;
            if (!vif.hsync) hsl++;
            if (!vif.vsync) vsl++;
            if (vif.line_start) begin
                if (last_ls >= 0 && i - last_ls != HT) gap_bad++;
                last_ls = i;
                lsn++;
            end
            if (vif.frame_start) fsn++;
            tick;
            adv();
        end
        chk("ungated_raster_err", errs, 0);
        chk("active_cycles", act, HA * VA);
        chk("active_in_vblank", act_vb, 0);
        chk("hsync_low_cycles", hsl, HS * VT);
        chk("vsync_low_cycles", vsl, VS * HT);
        chk("line_start_count", lsn, VT);
        chk("line_start_gap_bad", gap_bad, 0);
        chk("frame_start_count", fsn, 1);
        chk("frame2_frame_start", vif.frame_start, 1);
        chk("frame2_hpos", vif.hpos, 0);
        chk("frame_cnt_after_1", vif.frame_cnt, FCE ? 1 : 0);

        // alternating pix_en: same pixel sequence, outputs hold on idle cycles
        errs = 0; lsn = 0; gap_bad = 0; last_ls = -1; prev_ls = vif.line_start;
        for (int i = 0; i < 2 * FT; i++) begin
            vif.pix_en = (i % 2 == 1);
            tick;
            if (vif.pix_en) adv();
            model_cmp();
            if (vif.line_start && !prev_ls) begin
                if (last_ls >= 0 && i - last_ls != 2 * HT) gap_bad++;
                last_ls = i;
                lsn++;
            end
            prev_ls = vif.line_start;
        end
        chk("gated_raster_err", errs, 0);
        chk("gated_line_rises", lsn, VT);
        chk("gated_line_gap_bad", gap_bad, 0);
        chk("gated_end_frame_start", vif.frame_start, 1);
        chk("frame_cnt_after_2", vif.frame_cnt, FCE ? 2 : 0);

        // reset mid-frame at pixel (7,4), with pix_en low to show rst priority
        vif.pix_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < FT && !found; i++) begin
            tick;
            if (vif.hpos == CW'(7) && vif.vpos == CW'(4)) found = 1'b1;
        end
        chk("reach_7_4", found, 1);
        chk("active_at_7_4", vif.active, 1);
        rst = 1'b1;
        vif.pix_en = 1'b0;
        tick;
        chk("midrst_hpos", vif.hpos, 0);
        chk("midrst_vpos", vif.vpos, 0);
        chk("midrst_active", vif.active, 0);
        chk("midrst_hsync", vif.hsync, 1);
        chk("midrst_frame_cnt", vif.frame_cnt, 0);
        rst = 1'b0;
        vif.pix_en = 1'b1;
        tick;
        chk("restart_hpos", vif.hpos, 0);
        chk("restart_vpos", vif.vpos, 0);
        chk("restart_frame_start", vif.frame_start, 1);
        chk("restart_active", vif.active, 1);
        chk("dflt_restart_frame_start", dif.frame_start, 1);

        // 256 frames: frame counter sequence; first 800 cycles check default line timing
        k = 0; fc_err = 0; fc_max = 0;
        d_act = 0; d_hsl = 0; d_hbad = 0; d_ls = 0; d_vsl = 0;
        for (int j = 0; j < 256 * FT; j++) begin
            if (j < 800) begin
                if (dif.active) d_act++;
                if (!dif.vsync) d_vsl++;
                if (dif.line_start) d_ls++;
                if (!dif.hsync) begin
                    d_hsl++;
                    if (dif.hpos < 10'd656 || dif.hpos > 10'd751) d_hbad++;
                end
            end
            tick;
            if (vif.frame_start) begin
                k++;
                if (vif.frame_cnt !== (FCE ? 8'(k % 256) : 8'd0)) fc_err++;
            end
            if (int'(vif.frame_cnt) > fc_max) fc_max = int'(vif.frame_cnt);
        end
        chk("dflt_active_cycles", d_act, 640);
        chk("dflt_hsync_low", d_hsl, 96);
        chk("dflt_hsync_range_bad", d_hbad, 0);
        chk("dflt_line_start_count", d_ls, 1);
        chk("dflt_vsync_low_line0", d_vsl, 0);
        chk("fc_frames_seen", k, 256);
        chk("fc_seq_err", fc_err, 0);
        chk("fc_max", fc_max, FCE ? 255 : 0);
        chk("fc_wrap_to_0", vif.frame_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
